// File: rtl/lut_pkg.sv
// Shared types and helpers for the run-time programmable truth-table evaluator.
// Table bit order follows the hex-name convention: the MSB holds the output for index 0.
package lut_pkg;

    localparam int MAX_N_IN  = 6;
    localparam int MAX_TBL_W = 64;

    typedef logic [1:0] lut_state_t;

    localparam lut_state_t ST_RUN   = 2'd0;
    localparam lut_state_t ST_LOAD  = 2'd1;
    localparam lut_state_t ST_DRAIN = 2'd2;

    // Index 0 lives at bit tbl_w-1, so the lookup position is mirrored.
    function automatic logic tbl_bit(input logic [MAX_TBL_W-1:0] tbl,
                                     input logic [MAX_N_IN-1:0]  idx,
                                     input int unsigned          tbl_w);
        logic [MAX_N_IN-1:0] pos;
        pos = MAX_N_IN'(tbl_w - 32'd1) - idx;
        return tbl[pos];
    endfunction

endpackage

// File: rtl/lut_eval_pipe_if.sv
// Evaluation and configuration handshake bundle for lut_eval_pipe.
// master drives vectors and table bits, slave is the evaluator.
interface lut_eval_pipe_if #(
    parameter int N_IN = 3
) ();

    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_vec;
    logic            out_valid;
    logic            out_ready;
    logic            out_bit;
    logic [N_IN-1:0] out_idx;
    logic            cfg_start;
    logic            cfg_valid;
    logic            cfg_bit;
    logic            cfg_busy;
    logic            cfg_done;

    modport master (
        output in_valid, in_vec, out_ready, cfg_start, cfg_valid, cfg_bit,
        input  in_ready, out_valid, out_bit, out_idx, cfg_busy, cfg_done
    );

    modport slave (
        input  in_valid, in_vec, out_ready, cfg_start, cfg_valid, cfg_bit,
        output in_ready, out_valid, out_bit, out_idx, cfg_busy, cfg_done
    );

endinterface

// File: rtl/lut_cfg_shift.sv
// Shadow shift register and bit counter for serial truth-table loads.
// full is raised once TBL_W bits have been shifted in; further bits are ignored.
module lut_cfg_shift import lut_pkg::*; #(
    parameter int TBL_W = 8,
    parameter int CNT_W = $clog2(TBL_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [TBL_W-1:0] shadow,
    output logic             full
);

    logic [TBL_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign full   = (cnt_q == CNT_W'(TBL_W));
    assign shadow = shadow_q;

    // A restart only rewinds the counter; stale shadow bits get overwritten.
    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (shift_en && !full) begin
            shadow_d = {shadow_q[TBL_W-2:0], bit_in};
            cnt_d    = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Shadow and counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/lut_eval_pipe.sv
// Registered N_IN-input truth-table evaluator with valid/ready flow control
// and a serial port for swapping the table at run time.
module lut_eval_pipe import lut_pkg::*; #(
    parameter int               N_IN  = 3,
    parameter int               TBL_W = 2**N_IN,
    parameter logic [TBL_W-1:0] INIT  = 8'hCA
) (
    input  logic           clk,
    input  logic           rst,
    lut_eval_pipe_if.slave bus
);

    localparam int CNT_W = $clog2(TBL_W + 1);

    lut_state_t       state_q, state_d;
    logic [TBL_W-1:0] table_q, table_d;
    logic             out_valid_q, out_valid_d;
    logic             out_bit_q, out_bit_d;
    logic [N_IN-1:0]  out_idx_q, out_idx_d;
    logic             cfg_busy_q, cfg_busy_d;
    logic             cfg_done_q, cfg_done_d;

    logic             in_ready_s;
    logic             accept_s;
    logic             cfg_clear_s;
    logic             cfg_shift_s;
    logic             cfg_full_s;
    logic             drain_ok_s;
    logic [TBL_W-1:0] shadow_s;

    // The cycle carrying cfg_done still refuses input so the new table is settled first.
    assign in_ready_s  = !rst && (state_q == ST_RUN) && !cfg_done_q &&
                         (!out_valid_q || bus.out_ready);
    assign accept_s    = bus.in_valid && in_ready_s;
    assign cfg_clear_s = bus.cfg_start && ((state_q == ST_RUN) || (state_q == ST_LOAD));
    assign cfg_shift_s = (state_q == ST_LOAD) && bus.cfg_valid && !bus.cfg_start;
    assign drain_ok_s  = !out_valid_q || bus.out_ready;

    lut_cfg_shift #(
        .TBL_W (TBL_W),
        .CNT_W (CNT_W)
    ) u_cfg_shift (
        .clk      (clk),
        .rst      (rst),
        .clear    (cfg_clear_s),
        .shift_en (cfg_shift_s),
        .bit_in   (bus.cfg_bit),
        .shadow   (shadow_s),
        .full     (cfg_full_s)
    );

    // Load sequencing: commit only once the output register has emptied.
    always_comb begin
        state_d    = state_q;
        table_d    = table_q;
        cfg_busy_d = cfg_busy_q;
        cfg_done_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.cfg_start) begin
                    state_d    = ST_LOAD;
                    cfg_busy_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (bus.cfg_start) begin
                    state_d = ST_LOAD;
                end else if (cfg_full_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_ok_s) begin
                    table_d    = shadow_s;
                    cfg_done_d = 1'b1;
                    cfg_busy_d = 1'b0;
                    state_d    = ST_RUN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d    = ST_RUN;
                cfg_busy_d = 1'b0;
            end
        endcase
    end

    // Output register: load on accept, clear on pop, hold under backpressure.
    always_comb begin
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_idx_d   = out_idx_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_bit_d   = tbl_bit(MAX_TBL_W'(table_q), MAX_N_IN'(bus.in_vec), TBL_W);
            out_idx_d   = bus.in_vec;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State, table and output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            table_q     <= INIT;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_idx_q   <= '0;
            cfg_busy_q  <= 1'b0;
            cfg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            table_q     <= table_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_idx_q   <= out_idx_d;
            cfg_busy_q  <= cfg_busy_d;
            cfg_done_q  <= cfg_done_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.cfg_busy  = cfg_busy_q;
    assign bus.cfg_done  = cfg_done_q;

endmodule

// File: tb/tb_lut_eval_pipe.sv
// Scoreboard bench for lut_eval_pipe: a 3-input instance (INIT 8'hCA) and a
// 4-input instance (INIT 16'h8000) share clock and reset.
module tb_lut_eval_pipe;

    typedef struct {
        logic [3:0] idx;
        logic       b;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    bit   lat_chk = 1'b1;

    logic [7:0]  m_tbl8  = 8'hCA;
    logic [15:0] m_tbl16 = 16'h8000;
    exp_t sb8[$];
    exp_t sb16[$];

    lut_eval_pipe_if #(.N_IN(3)) b8 ();
    lut_eval_pipe_if #(.N_IN(4)) b16 ();

    lut_eval_pipe #(.N_IN(3)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    lut_eval_pipe #(.N_IN(4), .INIT(16'h8000)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Pop and compare 3-input results as they leave the DUT.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && b8.out_valid && b8.out_ready) begin
            if (sb8.size() == 0) begin
                check_eq("sb8_empty", 32'(sb8.size()), 32'd1);
            end else begin
                e = sb8.pop_front();
                check_eq("bit8", 32'(b8.out_bit), 32'(e.b));
                check_eq("idx8", 32'(b8.out_idx), 32'(e.idx));
                if (lat_chk) check_eq("lat8", cyc - e.cyc, 32'd1);
            end
        end
        if (!rst && b8.cfg_done) done_cnt++;
    end

    // Pop and compare 4-input results.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && b16.out_valid && b16.out_ready) begin
            if (sb16.size() == 0) begin
                check_eq("sb16_empty", 32'(sb16.size()), 32'd1);
            end else begin
                e = sb16.pop_front();
                check_eq("bit16", 32'(b16.out_bit), 32'(e.b));
                check_eq("idx16", 32'(b16.out_idx), 32'(e.idx));
                check_eq("lat16", cyc - e.cyc, 32'd1);
            end
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send8(input logic [2:0] v);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        b8.in_valid = 1'b1;
        b8.in_vec   = v;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (b8.in_ready) begin
                e.idx = 4'(v);
                e.b   = m_tbl8[7 - v];
                e.cyc = cyc;
                sb8.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check_eq("send8_timeout", 32'(b8.in_ready), 32'd1);
        b8.in_valid = 1'b0;
    endtask

    task automatic send16(input logic [3:0] v);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        b16.in_valid = 1'b1;
        b16.in_vec   = v;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (b16.in_ready) begin
                e.idx = v;
                e.b   = m_tbl16[15 - v];
                e.cyc = cyc;
                sb16.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check_eq("send16_timeout", 32'(b16.in_ready), 32'd1);
        b16.in_valid = 1'b0;
    endtask

    task automatic cfg_load8(input logic [7:0] val, input int nbits, input bit do_start);
        if (do_start) begin
            b8.cfg_start = 1'b1;
            step(1);
            b8.cfg_start = 1'b0;
        end
        for (int i = 0; i < nbits; i++) begin
            b8.cfg_valid = 1'b1;
            b8.cfg_bit   = val[7 - i];
            step(1);
            if (i % 3 == 1) begin
                b8.cfg_valid = 1'b0;
                step(1);
            end
        end
        b8.cfg_valid = 1'b0;
    endtask

    // Waits for cfg_done, then checks in_ready is low with it and high just after.
    task automatic wait_done8();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (b8.cfg_done) seen = 1'b1;
            else step(1);
        end
        if (!seen) check_eq("done_timeout", 32'(b8.cfg_done), 32'd1);
        check_eq("rdy_at_done", 32'(b8.in_ready), 32'd0);
        step(1);
        @(negedge clk);
        check_eq("rdy_after_done", 32'(b8.in_ready), 32'd1);
        step(1);
    endtask

    initial begin
        int d0;
        b8.in_valid  = 1'b0; b8.in_vec  = '0; b8.out_ready  = 1'b1;
        b8.cfg_start = 1'b0; b8.cfg_valid = 1'b0; b8.cfg_bit = 1'b0;
        b16.in_valid = 1'b0; b16.in_vec = '0; b16.out_ready = 1'b1;
        b16.cfg_start = 1'b0; b16.cfg_valid = 1'b0; b16.cfg_bit = 1'b0;

        // Reset state
        step(2);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(b8.in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(b8.out_valid), 32'd0);
        check_eq("rst_out_bit", 32'(b8.out_bit), 32'd0);
        check_eq("rst_out_idx", 32'(b8.out_idx), 32'd0);
        check_eq("rst_cfg_busy", 32'(b8.cfg_busy), 32'd0);
        check_eq("rst_cfg_done", 32'(b8.cfg_done), 32'd0);
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("run_in_ready", 32'(b8.in_ready), 32'd1);
        step(1);

        // Back-to-back stream through the reset table
        for (int i = 0; i < 8; i++) send8(3'(i));
        step(3);

        // Backpressure on the in_vec=4 result
        lat_chk = 1'b0;
        b8.out_ready = 1'b0;
        send8(3'd4);
        b8.in_valid = 1'b1;
        b8.in_vec   = 3'd5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("bp_valid", 32'(b8.out_valid), 32'd1);
            check_eq("bp_bit", 32'(b8.out_bit), 32'd1);
            check_eq("bp_idx", 32'(b8.out_idx), 32'd4);
            check_eq("bp_in_ready", 32'(b8.in_ready), 32'd0);
            step(1);
        end
        b8.out_ready = 1'b1;
        begin
            exp_t e;
            @(negedge clk);
            check_eq("bp_release_rdy", 32'(b8.in_ready), 32'd1);
            e.idx = 4'd5; e.b = m_tbl8[2]; e.cyc = cyc;
            if (b8.in_ready) sb8.push_back(e);
        end
        step(1);
        b8.in_valid = 1'b0;
        step(3);

        // Load 8'h96 while a result is held
        b8.out_ready = 1'b0;
        send8(3'd0);
        d0 = done_cnt;
        cfg_load8(8'h96, 8, 1'b1);
        step(4);
        @(negedge clk);
        check_eq("drain_no_done", done_cnt - d0, 32'd0);
        check_eq("drain_busy", 32'(b8.cfg_busy), 32'd1);
        check_eq("drain_held", 32'(b8.out_valid), 32'd1);
        check_eq("drain_in_ready", 32'(b8.in_ready), 32'd0);
        step(1);
        b8.out_ready = 1'b1;
        wait_done8();
        m_tbl8 = 8'h96;
        step(3);
        check_eq("done_once", done_cnt - d0, 32'd1);
        check_eq("busy_after_done", 32'(b8.cfg_busy), 32'd0);
        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) send8(3'(i));
        step(3);

        // Reset in the middle of a load drops the pending result
        lat_chk = 1'b0;
        b8.out_ready = 1'b0;
        send8(3'd1);
        cfg_load8(8'h00, 4, 1'b1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        sb8.delete();
        m_tbl8 = 8'hCA;
        @(negedge clk);
        check_eq("mid_rst_busy", 32'(b8.cfg_busy), 32'd0);
        check_eq("mid_rst_valid", 32'(b8.out_valid), 32'd0);
        step(1);
        b8.out_ready = 1'b1;
        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) send8(3'(i));
        step(3);

        // cfg_start in the same cycle as an accepted vector
        begin
            exp_t e;
            b8.in_valid  = 1'b1;
            b8.in_vec    = 3'd2;
            b8.cfg_start = 1'b1;
            @(negedge clk);
            check_eq("start_acc_rdy", 32'(b8.in_ready), 32'd1);
            e.idx = 4'd2; e.b = m_tbl8[5]; e.cyc = cyc;
            if (b8.in_ready) sb8.push_back(e);
            step(1);
            b8.in_valid  = 1'b0;
            b8.cfg_start = 1'b0;
            @(negedge clk);
            check_eq("start_next_rdy", 32'(b8.in_ready), 32'd0);
            check_eq("start_busy", 32'(b8.cfg_busy), 32'd1);
            step(1);
        end
        cfg_load8(8'h3C, 8, 1'b0);
        wait_done8();
        m_tbl8 = 8'h3C;
        for (int i = 0; i < 8; i++) send8(3'(i));
        step(3);

        // Four-input instance, one-hot table
        for (int i = 0; i < 16; i++) send16(4'(i));
        step(5);

        check_eq("sb8_left", 32'(sb8.size()), 32'd0);
        check_eq("sb16_left", 32'(sb16.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
